// File: rtl/load_store_unit_if.sv
// rtl/load_store_unit_if.sv - memory bus request/response bundle for the load/store unit
interface load_store_unit_if;
    logic        bus_req_valid;
    logic        bus_req_ready;
    logic        bus_req_write;
    logic [63:0] bus_req_addr;
    logic [63:0] bus_req_wdata;
    logic [7:0]  bus_req_strb;
    logic        bus_rsp_valid;
    logic [63:0] bus_rsp_data;

    modport master (
        output bus_req_valid,
        output bus_req_write,
        output bus_req_addr,
        output bus_req_wdata,
        output bus_req_strb,
        input  bus_req_ready,
        input  bus_rsp_valid,
        input  bus_rsp_data
    );

    modport slave (
        input  bus_req_valid,
        input  bus_req_write,
        input  bus_req_addr,
        input  bus_req_wdata,
        input  bus_req_strb,
        output bus_req_ready,
        output bus_rsp_valid,
        output bus_rsp_data
    );
endinterface

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - single-outstanding load/store unit with alignment check and bus timeout
module load_store_unit #(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    mem_read_en,
    input  logic                    mem_write_en,
    input  logic [1:0]              mem_size,
    input  logic                    mem_unsigned,
    input  logic [63:0]             addr,
    input  logic [63:0]             wdata,
    output logic                    stall,
    output logic                    done,
    output logic [63:0]             rdata,
    output logic                    misaligned,
    output logic                    bus_err,
    load_store_unit_if.master       bus
);

    // Counter must be able to hold TIMEOUT_CYCLES: a load accepted on the last
    // REQ cycle carries one increment past the limit into WAIT.
    localparam int            CW   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] TMAX = CW'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [1:0]    size_q;
    logic          unsigned_q;
    logic [2:0]    off_q;
    logic          write_q;
    logic          valid_q;
    logic [63:0]   req_addr_q;
    logic [63:0]   req_wdata_q;
    logic [7:0]    req_strb_q;
    logic          done_q;
    logic          misaligned_q;
    logic          bus_err_q;
    logic [63:0]   rdata_q;

    logic          access_c;
    logic          misalign_c;
    logic [7:0]    strb_c;
    logic [63:0]   wdata_c;
    logic [63:0]   shifted_c;
    logic [63:0]   load_c;

    assign access_c = mem_read_en | mem_write_en;

    // Alignment check and lane placement of the incoming request
    always_comb begin
        misalign_c = 1'b0;
        strb_c     = 8'h00;
        case (mem_size)
            SZ_B: begin
                misalign_c = 1'b0;
                strb_c     = 8'h01 << addr[2:0];
            end
            SZ_H: begin
                misalign_c = addr[0];
                strb_c     = 8'h03 << addr[2:0];
            end
            SZ_W: begin
                misalign_c = |addr[1:0];
                strb_c     = 8'h0F << addr[2:0];
            end
            default: begin
                misalign_c = |addr[2:0];
                strb_c     = 8'hFF;
            end
        endcase
        wdata_c = wdata << {addr[2:0], 3'b000};
    end

    // Right-justify the response lane and extend to 64 bits
    always_comb begin
        shifted_c = bus.bus_rsp_data >> {off_q, 3'b000};
        load_c    = shifted_c;
        case (size_q)
            SZ_B: load_c = unsigned_q ? {56'd0, shifted_c[7:0]}
                                      : {{56{shifted_c[7]}}, shifted_c[7:0]};
            SZ_H: load_c = unsigned_q ? {48'd0, shifted_c[15:0]}
                                      : {{48{shifted_c[15]}}, shifted_c[15:0]};
            SZ_W: load_c = unsigned_q ? {32'd0, shifted_c[31:0]}
                                      : {{32{shifted_c[31]}}, shifted_c[31:0]};
            default: load_c = shifted_c;
        endcase
    end

    // Access sequencer: all outputs are registered and set on the transition
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            size_q       <= 2'b00;
            unsigned_q   <= 1'b0;
            off_q        <= 3'b000;
            write_q      <= 1'b0;
            valid_q      <= 1'b0;
            req_addr_q   <= 64'd0;
            req_wdata_q  <= 64'd0;
            req_strb_q   <= 8'h00;
            done_q       <= 1'b0;
            misaligned_q <= 1'b0;
            bus_err_q    <= 1'b0;
            rdata_q      <= 64'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (access_c) begin
                        size_q      <= mem_size;
                        unsigned_q  <= mem_unsigned;
                        off_q       <= addr[2:0];
                        write_q     <= mem_write_en;
                        req_addr_q  <= {addr[63:3], 3'b000};
                        req_wdata_q <= wdata_c;
                        req_strb_q  <= strb_c;
                        if (misalign_c) begin
                            state_q      <= S_DONE;
                            done_q       <= 1'b1;
                            misaligned_q <= 1'b1;
                            rdata_q      <= 64'd0;
                        end else begin
                            state_q <= S_REQ;
                            valid_q <= 1'b1;
                            cnt_q   <= '0;
                        end
                    end
                end
                S_REQ: begin
                    // A handshake on the final allowed cycle still counts as accepted
                    if (bus.bus_req_ready) begin
                        valid_q <= 1'b0;
                        cnt_q   <= cnt_q + CW'(1);
                        if (write_q) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= S_WAIT;
                        end
                    end else if (cnt_q >= TMAX) begin
                        valid_q   <= 1'b0;
                        state_q   <= S_DONE;
                        done_q    <= 1'b1;
                        bus_err_q <= 1'b1;
                        rdata_q   <= 64'd0;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                S_WAIT: begin
                    if (bus.bus_rsp_valid) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                        rdata_q <= load_c;
                    end else if (cnt_q >= TMAX) begin
                        state_q   <= S_DONE;
                        done_q    <= 1'b1;
                        bus_err_q <= 1'b1;
                        rdata_q   <= 64'd0;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                S_DONE: begin
                    // Enables are ignored here; the core sees stall=0 this cycle
                    state_q      <= S_IDLE;
                    done_q       <= 1'b0;
                    misaligned_q <= 1'b0;
                    bus_err_q    <= 1'b0;
                    rdata_q      <= 64'd0;
                end
                default: begin
                    state_q <= S_IDLE;
                    valid_q <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign stall = ((state_q == S_IDLE) && access_c) ||
                   (state_q == S_REQ) || (state_q == S_WAIT);

    assign done       = done_q;
    assign rdata      = rdata_q;
    assign misaligned = misaligned_q;
    assign bus_err    = bus_err_q;

    assign bus.bus_req_valid = valid_q;
    assign bus.bus_req_write = write_q;
    assign bus.bus_req_addr  = req_addr_q;
    assign bus.bus_req_wdata = req_wdata_q;
    assign bus.bus_req_strb  = req_strb_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed table and sequence checks for load_store_unit
module tb_load_store_unit;

    logic        clk;
    logic        rst_n;
    logic        mem_read_en;
    logic        mem_write_en;
    logic [1:0]  mem_size;
    logic        mem_unsigned;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic        stall;
    logic        done;
    logic [63:0] rdata;
    logic        misaligned;
    logic        bus_err;

    int errors = 0;
    int checks = 0;

    load_store_unit_if bus_if ();

    load_store_unit #(.TIMEOUT_CYCLES(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .mem_read_en  (mem_read_en),
        .mem_write_en (mem_write_en),
        .mem_size     (mem_size),
        .mem_unsigned (mem_unsigned),
        .addr         (addr),
        .wdata        (wdata),
        .stall        (stall),
        .done         (done),
        .rdata        (rdata),
        .misaligned   (misaligned),
        .bus_err      (bus_err),
        .bus          (bus_if.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rd;
        logic        wr;
        logic        uns;
        logic [1:0]  size;
        logic [63:0] a;
        logic [63:0] wd;
        logic [63:0] rsp;
        int          exp_lat;
        logic        exp_mis;
        logic [7:0]  exp_strb;
        logic [63:0] exp_baddr;
        logic [63:0] exp_bwdata;
        logic [63:0] exp_rdata;
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        mem_read_en  = 1'b0;
        mem_write_en = 1'b0;
        mem_size     = 2'b00;
        mem_unsigned = 1'b0;
        addr         = 64'd0;
        wdata        = 64'd0;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int          lat;
        logic        got_done;
        logic        saw_req;
        logic        rsp_next;
        logic [7:0]  s_strb;
        logic [63:0] s_addr;
        logic [63:0] s_wdata;
        logic        s_write;
        logic [63:0] r_rdata;
        logic        r_mis;
        logic        r_err;
        lat = 0; got_done = 0; saw_req = 0; rsp_next = 0;
        s_strb = 0; s_addr = 0; s_wdata = 0; s_write = 0;
        r_rdata = 0; r_mis = 0; r_err = 0;
        @(negedge clk);
        mem_read_en  = v.rd;
        mem_write_en = v.wr;
        mem_size     = v.size;
        mem_unsigned = v.uns;
        addr         = v.a;
        wdata        = v.wd;
        bus_if.bus_req_ready = 1'b1;
        #1;
        check($sformatf("v%0d stall_detect", idx), 64'(stall), 64'd1);
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            bus_if.bus_rsp_valid = 1'b0;
            if (done) begin
                got_done = 1; lat = c;
                r_rdata = rdata; r_mis = misaligned; r_err = bus_err;
                break;
            end
            if (bus_if.bus_req_valid) begin
                saw_req = 1;
                s_strb  = bus_if.bus_req_strb;
                s_addr  = bus_if.bus_req_addr;
                s_wdata = bus_if.bus_req_wdata;
                s_write = bus_if.bus_req_write;
            end
            if (rsp_next) begin
                bus_if.bus_rsp_valid = 1'b1;
                bus_if.bus_rsp_data  = v.rsp;
                rsp_next = 0;
            end
            if (bus_if.bus_req_valid && bus_if.bus_req_ready && !bus_if.bus_req_write)
                rsp_next = 1;
        end
        check($sformatf("v%0d done_seen", idx), 64'(got_done), 64'd1);
        check($sformatf("v%0d latency", idx), 64'(lat), 64'(v.exp_lat));
        check($sformatf("v%0d misaligned", idx), 64'(r_mis), 64'(v.exp_mis));
        check($sformatf("v%0d bus_err", idx), 64'(r_err), 64'd0);
        check($sformatf("v%0d rdata", idx), r_rdata, v.exp_rdata);
        check($sformatf("v%0d bus_req_seen", idx), 64'(saw_req), 64'(!v.exp_mis));
        if (saw_req) begin
            check($sformatf("v%0d strb", idx), 64'(s_strb), 64'(v.exp_strb));
            check($sformatf("v%0d req_addr", idx), s_addr, v.exp_baddr);
            check($sformatf("v%0d req_wdata", idx), s_wdata, v.exp_bwdata);
            check($sformatf("v%0d req_write", idx), 64'(s_write), 64'(v.wr));
        end
        drive_idle();
        bus_if.bus_rsp_valid = 1'b0;
        @(negedge clk);
        check($sformatf("v%0d idle_done", idx), 64'(done), 64'd0);
        check($sformatf("v%0d idle_stall", idx), 64'(stall), 64'd0);
        check($sformatf("v%0d idle_valid", idx), 64'(bus_if.bus_req_valid), 64'd0);
    endtask

    initial begin
        logic [63:0] a0;
        logic [7:0]  s0;

        //            rd wr un sz     addr                   wdata                  rsp                    lat mis strb    req_addr              req_wdata              rdata
        vecs[0]  = '{0, 1, 0, 2'b00, 64'h1003,             64'hAB,                64'h0,                 2, 0, 8'h08, 64'h1000,             64'hAB00_0000,         64'h0};
        vecs[1]  = '{1, 0, 0, 2'b01, 64'h2006,             64'h0,                 64'h8001_0000_0000_0000, 3, 0, 8'hC0, 64'h2000,           64'h0,                 64'hFFFF_FFFF_FFFF_8001};
        vecs[2]  = '{1, 0, 1, 2'b01, 64'h2006,             64'h0,                 64'h8001_0000_0000_0000, 3, 0, 8'hC0, 64'h2000,           64'h0,                 64'h8001};
        vecs[3]  = '{1, 0, 0, 2'b10, 64'h3002,             64'h0,                 64'h0,                 1, 1, 8'h00, 64'h0,                64'h0,                 64'h0};
        vecs[4]  = '{1, 0, 0, 2'b00, 64'h4005,             64'h0,                 64'h0000_8000_0000_0000, 3, 0, 8'h20, 64'h4000,           64'h0,                 64'hFFFF_FFFF_FFFF_FF80};
        vecs[5]  = '{1, 0, 1, 2'b00, 64'h4005,             64'h0,                 64'h0000_8000_0000_0000, 3, 0, 8'h20, 64'h4000,           64'h0,                 64'h80};
        vecs[6]  = '{1, 0, 0, 2'b10, 64'h5004,             64'h0,                 64'h89AB_CDEF_0123_4567, 3, 0, 8'hF0, 64'h5000,           64'h0,                 64'hFFFF_FFFF_89AB_CDEF};
        vecs[7]  = '{1, 0, 1, 2'b10, 64'h5004,             64'h0,                 64'h89AB_CDEF_0123_4567, 3, 0, 8'hF0, 64'h5000,           64'h0,                 64'h0000_0000_89AB_CDEF};
        vecs[8]  = '{1, 0, 0, 2'b11, 64'h6000,             64'h0,                 64'h8123_4567_89AB_CDEF, 3, 0, 8'hFF, 64'h6000,           64'h0,                 64'h8123_4567_89AB_CDEF};
        vecs[9]  = '{0, 1, 0, 2'b11, 64'h7000,             64'h1122_3344_5566_7788, 64'h0,               2, 0, 8'hFF, 64'h7000,             64'h1122_3344_5566_7788, 64'h0};
        vecs[10] = '{0, 1, 0, 2'b01, 64'h8002,             64'hFFFF_FFFF_FFFF_BEEF, 64'h0,               2, 0, 8'h0C, 64'h8000,             64'hFFFF_FFFF_BEEF_0000, 64'h0};
        vecs[11] = '{0, 1, 0, 2'b11, 64'h9004,             64'h1234,              64'h0,                 1, 1, 8'h00, 64'h0,                64'h0,                 64'h0};
        vecs[12] = '{1, 0, 0, 2'b01, 64'hA001,             64'h0,                 64'h0,                 1, 1, 8'h00, 64'h0,                64'h0,                 64'h0};
        vecs[13] = '{1, 1, 0, 2'b00, 64'hB007,             64'h5A,                64'h0,                 2, 0, 8'h80, 64'hB000,             64'h5A00_0000_0000_0000, 64'h0};
        vecs[14] = '{1, 0, 1, 2'b11, 64'hC008,             64'h0,                 64'h8000_0000_0000_0001, 3, 0, 8'hFF, 64'hC008,           64'h0,                 64'h8000_0000_0000_0001};

        drive_idle();
        bus_if.bus_req_ready = 1'b0;
        bus_if.bus_rsp_valid = 1'b0;
        bus_if.bus_rsp_data  = 64'd0;
        rst_n = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst done", 64'(done), 64'd0);
        check("rst rdata", rdata, 64'd0);
        check("rst misaligned", 64'(misaligned), 64'd0);
        check("rst bus_err", 64'(bus_err), 64'd0);
        check("rst valid", 64'(bus_if.bus_req_valid), 64'd0);
        check("rst stall_low", 64'(stall), 64'd0);
        mem_read_en = 1'b1;
        #1;
        check("rst stall_follows_en", 64'(stall), 64'd1);
        mem_read_en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Table of single accesses, ready always high
        for (int i = 0; i < 15; i++) run_vec(vecs[i], i);

        // LD with ready held low for 5 REQ cycles
        @(negedge clk);
        mem_read_en = 1'b1; mem_size = 2'b11; addr = 64'hD010;
        bus_if.bus_req_ready = 1'b0;
        @(negedge clk);
        a0 = bus_if.bus_req_addr;
        s0 = bus_if.bus_req_strb;
        check("hold addr", a0, 64'hD010);
        for (int c = 1; c <= 5; c++) begin
            if (c > 1) @(negedge clk);
            check($sformatf("hold valid c%0d", c), 64'(bus_if.bus_req_valid), 64'd1);
            check($sformatf("hold stall c%0d", c), 64'(stall), 64'd1);
            check($sformatf("hold addr c%0d", c), bus_if.bus_req_addr, a0);
            check($sformatf("hold strb c%0d", c), 64'(bus_if.bus_req_strb), 64'(s0));
        end
        @(negedge clk);
        check("hold valid c6", 64'(bus_if.bus_req_valid), 64'd1);
        bus_if.bus_req_ready = 1'b1;
        @(negedge clk);
        check("hold wait valid", 64'(bus_if.bus_req_valid), 64'd0);
        check("hold wait stall", 64'(stall), 64'd1);
        bus_if.bus_rsp_valid = 1'b1;
        bus_if.bus_rsp_data  = 64'h0102_0304_0506_0708;
        @(negedge clk);
        bus_if.bus_rsp_valid = 1'b0;
        check("hold done", 64'(done), 64'd1);
        check("hold rdata", rdata, 64'h0102_0304_0506_0708);
        check("hold stall_done", 64'(stall), 64'd0);
        drive_idle();
        @(negedge clk);

        // LD accepted, no response: timeout after 8 REQ/WAIT cycles
        mem_read_en = 1'b1; mem_size = 2'b11; addr = 64'hE000;
        bus_if.bus_req_ready = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            check($sformatf("tmo_ld no_done c%0d", c), 64'(done | bus_err), 64'd0);
        end
        @(negedge clk);
        check("tmo_ld done", 64'(done), 64'd1);
        check("tmo_ld bus_err", 64'(bus_err), 64'd1);
        check("tmo_ld rdata", rdata, 64'd0);
        check("tmo_ld stall", 64'(stall), 64'd0);
        drive_idle();
        @(negedge clk);
        check("tmo_ld err_pulse", 64'(bus_err), 64'd0);

        // Store never accepted: timeout in REQ drops valid
        mem_write_en = 1'b1; mem_size = 2'b10; addr = 64'hE100; wdata = 64'h55;
        bus_if.bus_req_ready = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            check($sformatf("tmo_st valid c%0d", c), 64'(bus_if.bus_req_valid), 64'd1);
        end
        @(negedge clk);
        check("tmo_st bus_err", 64'(bus_err), 64'd1);
        check("tmo_st valid_drop", 64'(bus_if.bus_req_valid), 64'd0);
        drive_idle();
        @(negedge clk);

        // Enables held through DONE are ignored there, then start a new access in IDLE
        mem_write_en = 1'b1; mem_size = 2'b00; addr = 64'hF001; wdata = 64'h11;
        bus_if.bus_req_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("done_hold done", 64'(done), 64'd1);
        check("done_hold stall", 64'(stall), 64'd0);
        @(negedge clk);
        check("done_hold back_idle", 64'(done), 64'd0);
        check("done_hold no_valid", 64'(bus_if.bus_req_valid), 64'd0);
        check("done_hold restall", 64'(stall), 64'd1);
        drive_idle();
        @(negedge clk);
        check("done_hold quiet", 64'(bus_if.bus_req_valid), 64'd0);

        // Reset mid-REQ drops valid immediately
        mem_read_en = 1'b1; mem_size = 2'b11; addr = 64'hF100;
        bus_if.bus_req_ready = 1'b0;
        @(negedge clk);
        check("rst_req valid_before", 64'(bus_if.bus_req_valid), 64'd1);
        rst_n = 1'b0;
        #1;
        check("rst_req valid_drop", 64'(bus_if.bus_req_valid), 64'd0);
        drive_idle();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset in WAIT, then a late response is ignored
        mem_read_en = 1'b1; mem_size = 2'b11; addr = 64'hF200;
        bus_if.bus_req_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_wait stall", 64'(stall), 64'd1);
        check("rst_wait in_wait", 64'(bus_if.bus_req_valid), 64'd0);
        rst_n = 1'b0;
        drive_idle();
        @(negedge clk);
        rst_n = 1'b1;
        bus_if.bus_rsp_valid = 1'b1;
        bus_if.bus_rsp_data  = 64'hDEAD_BEEF_0000_0001;
        for (int c = 1; c <= 2; c++) begin
            @(negedge clk);
            bus_if.bus_rsp_valid = 1'b0;
            check($sformatf("rst_wait no_done c%0d", c), 64'(done), 64'd0);
            check($sformatf("rst_wait rdata c%0d", c), rdata, 64'd0);
            check($sformatf("rst_wait stall c%0d", c), 64'(stall), 64'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 256: maximum cycles one access may spend in REQ plus WAIT.
REQ-002 One clock; reset is asynchronous and active-low.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 mem_read_en  input  1  load requested by the control decoder.
REQ-006 mem_write_en  input  1  store requested by the control decoder.
REQ-007 mem_size  input  2  00 byte, 01 half, 10 word, 11 doubleword.
REQ-008 mem_unsigned  input  1  zero-extend the load result.
REQ-009 addr  input  64  effective byte address.
REQ-010 wdata  input  64  store data, right-justified.
REQ-011 stall  output  1  holds the core PC and register write.
REQ-012 done  output  1  one-cycle completion pulse.
REQ-013 rdata  output  64  extended load result, valid while done=1.
REQ-014 misaligned  output  1  one-cycle pulse, alignment fault.
REQ-015 bus_err  output  1  one-cycle pulse, timeout fault.
REQ-016 bus_req_valid / bus_req_ready  output / input  1 / 1  request handshake.
REQ-017 bus_req_write  output  1  request is a store.
REQ-018 bus_req_addr  output  64  addr with bits [2:0] forced to 0.
REQ-019 bus_req_wdata  output  64  store data shifted into its byte lanes.
REQ-020 bus_req_strb  output  8  byte-lane enables.
REQ-021 bus_rsp_valid / bus_rsp_data  input / input  1 / 64  load response.

Function
REQ-022 The FSM SHALL have four states: IDLE, REQ, WAIT, DONE.
REQ-023 In IDLE with either enable high, the unit SHALL latch all request inputs.
- If both enables are high, the access is a store.
REQ-024 Alignment SHALL be checked in IDLE:
- half needs addr[0]=0, word needs addr[1:0]=0, doubleword needs addr[2:0]=0.
- A misaligned access goes to DONE with misaligned=1, rdata=0 and no bus request.
REQ-025 An aligned access SHALL go to REQ.
- bus_req_valid=1 in REQ, with all bus_req_* fields held stable until bus_req_ready=1.
REQ-026 On the REQ handshake, a store SHALL go to DONE and a load SHALL go to WAIT.
REQ-027 bus_rsp_valid SHALL be ignored in every state except WAIT.
- In WAIT, bus_rsp_valid=1 captures the extended data and goes to DONE.
REQ-028 bus_req_strb SHALL be 0x01, 0x03, 0x0F or 0xFF for byte, half, word and doubleword, shifted left by addr[2:0].
- bus_req_wdata SHALL be wdata shifted left by 8*addr[2:0].
REQ-029 Load extraction SHALL be: bus_rsp_data shifted right by 8*addr[2:0], truncated to the access size, then sign-extended or zero-extended to 64 bits.
- mem_unsigned SHALL be ignored for doubleword accesses.
REQ-030 stall SHALL be combinational: (IDLE and either enable high) or REQ or WAIT; stall=0 in DONE.
REQ-031 DONE SHALL last exactly one cycle with done=1, ignore all enables, then return to IDLE.
REQ-032 The timeout counter SHALL clear on entry to REQ and increment each cycle in REQ or WAIT.
- On reaching TIMEOUT_CYCLES, the unit goes to DONE with bus_err=1 and rdata=0, and bus_req_valid drops.
REQ-033 Minimum latency SHALL be: store 2 cycles from IDLE detect to DONE; load 3 cycles when the response arrives the cycle after acceptance.

Reset
REQ-034 While rst_n=0, the state SHALL be IDLE, the counter 0, and all outputs 0 except stall, which follows REQ-030.
REQ-035 A reset asserted mid-access SHALL drop bus_req_valid immediately and abandon the access; a later bus_rsp_valid SHALL be ignored.

Verification
REQ-036 SB, addr=0x1003, wdata=0xAB, ready=1 -> strb=0x08, wdata lane 3=0xAB, bus_req_addr=0x1000, done at cycle 2.
REQ-037 LH, addr=0x2006, response 0x8001_0000_0000_0000 one cycle after accept -> rdata=0xFFFF_FFFF_FFFF_8001, done at cycle 3; LHU -> 0x8001.
REQ-038 LW, addr=0x3002 -> misaligned=1, done=1, no bus_req_valid, returns to IDLE the next cycle.
REQ-039 LD with ready held 0 for 5 cycles -> bus_req fields stable throughout, stall=1 until DONE.
REQ-040 LD with no response, TIMEOUT_CYCLES=8 -> bus_err=1 and rdata=0 after 8 REQ/WAIT cycles.
REQ-041 rst_n asserted in WAIT, then a response arrives -> unit in IDLE, no done pulse, rdata=0.
